// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: state encodings
// and the major opcode values the control path decodes.
package core_sequencer_pkg;

  // Encoding is visible on the STATE debug port, so values are fixed.
  typedef enum logic [2:0] {
    SeqIdle   = 3'd0,
    SeqFetch  = 3'd1,
    SeqDecode = 3'd2,
    SeqExec   = 3'd3,
    SeqMem    = 3'd4,
    SeqWb     = 3'd5,
    SeqTrap   = 3'd6
  } seq_state_e;

  localparam logic [6:0] OpcodeLui     = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc   = 7'b0010111;
  localparam logic [6:0] OpcodeJal     = 7'b1101111;
  localparam logic [6:0] OpcodeJalr    = 7'b1100111;
  localparam logic [6:0] OpcodeBranch  = 7'b1100011;
  localparam logic [6:0] OpcodeLoad    = 7'b0000011;
  localparam logic [6:0] OpcodeStore   = 7'b0100011;
  localparam logic [6:0] OpcodeOpImm   = 7'b0010011;
  localparam logic [6:0] OpcodeOp      = 7'b0110011;
  localparam logic [6:0] OpcodeMiscMem = 7'b0001111;
  localparam logic [6:0] OpcodeSystem  = 7'b1110011;

  // True for the major opcodes of the base RV32I set.
  function automatic logic is_rv32i(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OpcodeLui, OpcodeAuipc, OpcodeJal, OpcodeJalr, OpcodeBranch, OpcodeLoad,
      OpcodeStore, OpcodeOpImm, OpcodeOp, OpcodeMiscMem, OpcodeSystem: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Only loads and stores visit the MEM phase.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OpcodeLoad) || (op == OpcodeStore);
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// issuing one-state stage enables and counting retired instructions.
// Optional feature macro: CORE_SEQ_TRAP_EN (illegal opcodes halt in TRAP).
module core_sequencer
  import core_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        NRST,
  input  logic        ENABLE,
  input  logic [6:0]  OPCODE,
  input  logic        IMEM_ACK,
  input  logic        DMEM_ACK,
  output logic        IMEM_REQ,
  output logic        DMEM_REQ,
  output logic        C_FETCH,
  output logic        C_DECODE,
  output logic        C_EXEC,
  output logic        C_MEM,
  output logic        C_WB,
  output logic        PC_UPDATE,
  output logic        TRAP,
  output logic [31:0] INSTRET,
  output logic [2:0]  STATE
);

  seq_state_e  state_q, state_d;
  logic [31:0] instret_q;
  logic        instret_inc;

  // State register; reset parks the sequencer in IDLE immediately.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= SeqIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, bumped once per WB; wraps naturally.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      instret_q <= '0;
    end else if (instret_inc) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  // Next-state and stage strobes; FETCH/MEM strobes are Mealy on the ACKs.
  always_comb begin
    state_d     = state_q;
    IMEM_REQ    = 1'b0;
    DMEM_REQ    = 1'b0;
    C_FETCH     = 1'b0;
    C_DECODE    = 1'b0;
    C_EXEC      = 1'b0;
    C_MEM       = 1'b0;
    C_WB        = 1'b0;
    PC_UPDATE   = 1'b0;
    instret_inc = 1'b0;
    unique case (state_q)
      SeqIdle: begin
        if (ENABLE) state_d = SeqFetch;
      end
      SeqFetch: begin
        IMEM_REQ = 1'b1;
        C_FETCH  = IMEM_ACK;
        if (IMEM_ACK) state_d = SeqDecode;
      end
      SeqDecode: begin
        C_DECODE = 1'b1;
        state_d  = SeqExec;
      end
      SeqExec: begin
        C_EXEC = 1'b1;
        if (is_mem_op(OPCODE)) state_d = SeqMem;
        else                   state_d = SeqWb;
`ifdef CORE_SEQ_TRAP_EN
        if (!is_rv32i(OPCODE)) state_d = SeqTrap;
`endif
      end
      SeqMem: begin
        DMEM_REQ = 1'b1;
        C_MEM    = DMEM_ACK;
        if (DMEM_ACK) state_d = SeqWb;
      end
      SeqWb: begin
        C_WB        = 1'b1;
        PC_UPDATE   = 1'b1;
        instret_inc = 1'b1;
        state_d     = ENABLE ? SeqFetch : SeqIdle;
      end
      // Sticky until reset; ENABLE deliberately ignored.
      SeqTrap: state_d = SeqTrap;
      default: state_d = SeqIdle;
    endcase
  end

`ifdef CORE_SEQ_TRAP_EN
  assign TRAP = (state_q == SeqTrap);
`else
  assign TRAP = 1'b0;
`endif

  assign INSTRET = instret_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes one expected record per
// busy cycle; the monitor pops and compares on every negedge the DUT is busy.
module tb_core_sequencer;

  logic        CLK, NRST, ENABLE, IMEM_ACK, DMEM_ACK;
  logic [6:0]  OPCODE;
  logic        IMEM_REQ, DMEM_REQ, C_FETCH, C_DECODE, C_EXEC, C_MEM, C_WB;
  logic        PC_UPDATE, TRAP;
  logic [31:0] INSTRET;
  logic [2:0]  STATE;

  core_sequencer dut (
    .CLK(CLK), .NRST(NRST), .ENABLE(ENABLE), .OPCODE(OPCODE),
    .IMEM_ACK(IMEM_ACK), .DMEM_ACK(DMEM_ACK), .IMEM_REQ(IMEM_REQ), .DMEM_REQ(DMEM_REQ),
    .C_FETCH(C_FETCH), .C_DECODE(C_DECODE), .C_EXEC(C_EXEC), .C_MEM(C_MEM), .C_WB(C_WB),
    .PC_UPDATE(PC_UPDATE), .TRAP(TRAP), .INSTRET(INSTRET), .STATE(STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // {IMEM_REQ, DMEM_REQ, C_FETCH, C_DECODE, C_EXEC, C_MEM, C_WB, PC_UPDATE, TRAP, STATE}
  typedef struct packed {
    logic [11:0] outs;
    logic [31:0] cnt;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;
  bit          in_fetch;

  function automatic rec_t mk(input bit ir, input bit dr, input bit cf, input bit cd,
                              input bit ce, input bit cm, input bit cw, input bit pu,
                              input bit tr, input logic [2:0] st, input logic [31:0] cnt);
    rec_t r;
    r.outs = {ir, dr, cf, cd, ce, cm, cw, pu, tr, st};
    r.cnt  = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic go_next();
    @(posedge CLK);
    #1;
  endtask

  // One full instruction. Entered at posedge+1 in IDLE (or FETCH if in_fetch).
  task automatic run(input logic [6:0] op, input int iw, input int dw,
                     input bit drop_dec, input bit keep_en);
    bit mem;
    mem = (op == 7'b0000011) || (op == 7'b0100011);
    OPCODE = op;
    if (!in_fetch) begin
      ENABLE = 1'b1;
      go_next();
    end
    for (int k = 0; k <= iw; k++) begin
      IMEM_ACK = (k == iw);
      exp_q.push_back(mk(1, 0, k == iw, 0, 0, 0, 0, 0, 0, 3'd1, exp_cnt));
      go_next();
    end
    IMEM_ACK = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3'd2, exp_cnt));
    if (drop_dec) ENABLE = 1'b0;
    go_next();
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd3, exp_cnt));
    go_next();
    if (mem) begin
      for (int k = 0; k <= dw; k++) begin
        DMEM_ACK = (k == dw);
        exp_q.push_back(mk(0, 1, 0, 0, 0, k == dw, 0, 0, 0, 3'd4, exp_cnt));
        go_next();
      end
      DMEM_ACK = 1'b0;
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 3'd5, exp_cnt));
    exp_cnt  = exp_cnt + 32'd1;
    ENABLE   = keep_en && !drop_dec;
    in_fetch = keep_en && !drop_dec;
    go_next();
  endtask

  task automatic drain(input string name);
    repeat (2) go_next();
    chk(name, exp_q.size(), 0);
    chk({name, "_instret"}, INSTRET, exp_cnt);
  endtask

  initial begin
    NRST = 1'b0; ENABLE = 1'b0; OPCODE = 7'h00; IMEM_ACK = 1'b0; DMEM_ACK = 1'b0;
    exp_cnt = 32'd0; in_fetch = 1'b0;
    fork
      // Monitor: any busy cycle must match the head of the scoreboard.
      forever begin
        rec_t act, req;
        @(negedge CLK);
        act.outs = {IMEM_REQ, DMEM_REQ, C_FETCH, C_DECODE, C_EXEC, C_MEM, C_WB,
                    PC_UPDATE, TRAP, STATE};
        act.cnt  = INSTRET;
        if (NRST && act.outs != 12'd0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_activity actual=%h required=idle", act);
          end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
              errors++;
              $display("FAIL seq_record actual=%h required=%h", act, req);
            end
          end
        end
      end
      // Stimulus
      begin
        #12;
        chk("reset_state", {29'd0, STATE}, 0);
        chk("reset_instret", INSTRET, 0);
        chk("reset_outs", {IMEM_REQ, DMEM_REQ, C_FETCH, C_WB, TRAP}, 0);
        @(posedge CLK); #1; NRST = 1'b1;
        go_next();

        run(7'b0010011, 0, 0, 0, 0);          // ADDI, 4 cycles
        drain("addi");
        run(7'b0000011, 0, 3, 0, 0);          // LOAD, DMEM_ACK after 3 waits
        drain("load_wait");
        run(7'b0100011, 2, 0, 0, 1);          // STORE with fetch waits, back-to-back
        run(7'b0110011, 0, 0, 0, 0);          // OP, no bubble after WB
        drain("b2b");

        run(7'b1101111, 0, 0, 1, 0);          // JAL, ENABLE dropped in DECODE
        for (int i = 0; i < 5; i++) begin
          chk("parked_state", {29'd0, STATE}, 0);
          chk("parked_imem_req", {31'd0, IMEM_REQ}, 0);
          go_next();
        end
        run(7'b1100011, 0, 0, 0, 0);          // BRANCH once ENABLE returns
        drain("resume");

        // Asynchronous reset while waiting in MEM
        ENABLE = 1'b1; OPCODE = 7'b0000011; IMEM_ACK = 1'b1;
        go_next();
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 3'd1, exp_cnt));
        go_next();
        IMEM_ACK = 1'b0; ENABLE = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3'd2, exp_cnt));
        go_next();
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd3, exp_cnt));
        go_next();
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 3'd4, exp_cnt));
        @(negedge CLK); #2;
        chk("pre_reset_dmem_req", {31'd0, DMEM_REQ}, 1);
        chk("pre_reset_instret", INSTRET, 32'd6);
        NRST = 1'b0;
        #1;
        chk("async_dmem_req", {31'd0, DMEM_REQ}, 0);
        chk("async_state", {29'd0, STATE}, 0);
        chk("async_instret", INSTRET, 0);
        exp_cnt = 32'd0;
        go_next();
        NRST = 1'b1;
        drain("after_reset");

        // Counter wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_cnt = 32'hFFFF_FFFF;
        chk("wrap_preload", INSTRET, 32'hFFFF_FFFF);
        run(7'b0010011, 0, 0, 0, 0);
        drain("wrap");

        // Opcode outside RV32I
`ifdef CORE_SEQ_TRAP_EN
        ENABLE = 1'b1; OPCODE = 7'b1111111; IMEM_ACK = 1'b1;
        go_next();
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 3'd1, exp_cnt));
        go_next();
        IMEM_ACK = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3'd2, exp_cnt));
        go_next();
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 3'd3, exp_cnt));
        go_next();
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd6, exp_cnt));
          go_next();
        end
        chk("trap_flag", {31'd0, TRAP}, 1);
        chk("trap_state", {29'd0, STATE}, 6);
        chk("trap_instret", INSTRET, exp_cnt);
        NRST = 1'b0;
        #1;
        chk("trap_cleared", {31'd0, TRAP}, 0);
        exp_cnt = 32'd0; ENABLE = 1'b0;
        go_next();
        NRST = 1'b1;
        drain("trap_exit");
`else
        run(7'b1111111, 0, 0, 0, 0);
        drain("unknown_op");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_any
  end

endmodule
